bin_to_bcd: RTL

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/bin_to_bcd_pkg.sv | 25 ++
 rtl/bin_to_bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd.sv | 117 +++++++++++
 3 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W_DEF  = 32;
  localparam int DIGITS_DEF = 8;

  // Error pattern: every digit reads F on the seven-segment display.
  localparam logic [3:0]              BCD_ERR_DIGIT = 4'hF;
  localparam logic [4*DIGITS_DEF-1:0] BCD_ERR       = {DIGITS_DEF{BCD_ERR_DIGIT}};

  // Largest value representable in the given number of decimal digits.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Handshake: a request is taken on a rising edge with valid_i=1 and ready_o=1;
// valid_o pulses for one cycle with the result, with no backpressure on it.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [BIN_W-1:0]    bin_i,
  output logic                ready_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                valid_o,
  output logic                ovf_o,
  output state_t              dbg_state_o
);

  localparam int                CNT_W    = $clog2(BIN_W) + 1;
  localparam int                BCD_W    = 4 * DIGITS;
  localparam logic [63:0]       MAX      = bcd_max(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      scr_q      <= '0;
      bin_q      <= '0;
      ovf_pend_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scr_q      <= scr_d;
      bin_q      <= bin_d;
      ovf_pend_q <= ovf_pend_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    scr_d      = scr_q;
    bin_d      = bin_q;
    ovf_pend_d = ovf_pend_q;
    valid_d    = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    ready_d    = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          cnt_d      = '0;
          scr_d      = '0;
          bin_d      = bin_i;
          ovf_pend_d = (64'(bin_i) > MAX);
        end
      end
      SHIFT: begin
        // Top scratch bit falls off; overflow is already decided at accept.
        scr_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: begin
        valid_d = 1'b1;
        ovf_d   = ovf_pend_q;
        bcd_d   = ovf_pend_q ? {DIGITS{BCD_ERR_DIGIT}} : scr_q;
      end
      default: ;
    endcase
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign bcd_o       = bcd_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule
